// File: rtl/conv_out_streamer_pkg.sv
// rtl/conv_out_streamer_pkg.sv - shared widths, state enum and beat indices for conv_out_streamer
// CONV_OUT_MAXPOOL_EN selects a fifth max-pool beat and moves LAST_IDX to IDX_POOL.
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_O00  = 3'd0;
    localparam logic [IDX_W-1:0] IDX_O01  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_O10  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_O11  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_POOL = 3'd4;

`ifdef CONV_OUT_MAXPOOL_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_POOL;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_O11;
`endif

endpackage

// File: rtl/conv_out_streamer_if.sv
// rtl/conv_out_streamer_if.sv - tile capture and output stream bundle for conv_out_streamer
// master: the streamer itself; slave: the core/writeback side driving tiles and ready.
interface conv_out_streamer_if #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int IDX_W  = conv_pkg::IDX_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] o00;
    logic [DATA_W-1:0] o01;
    logic [DATA_W-1:0] o10;
    logic [DATA_W-1:0] o11;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [IDX_W-1:0]  m_idx;

    modport master (
        input  in_valid, o00, o01, o10, o11, m_ready,
        output in_ready, m_data, m_valid, m_last, m_idx
    );

    modport slave (
        output in_valid, o00, o01, o10, o11, m_ready,
        input  in_ready, m_data, m_valid, m_last, m_idx
    );
endinterface

// File: rtl/conv_out_streamer_max4.sv
// rtl/conv_out_streamer_max4.sv - combinational unsigned 4-input maximum, two-level compare tree
module max4_u #(
    parameter int W = conv_pkg::DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);
    logic [W-1:0] m_ab;
    logic [W-1:0] m_cd;

    always_comb begin
        m_ab = (a >= b) ? a : b;
        m_cd = (c >= d) ? c : d;
        y    = (m_ab >= m_cd) ? m_ab : m_cd;
    end
endmodule

// File: rtl/conv_out_streamer.sv
// rtl/conv_out_streamer.sv - captures a 2x2 conv tile and streams it in raster order
// CONV_OUT_MAXPOOL_EN appends the registered max of the tile as beat 4.
module conv_out_streamer #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int IDX_W  = conv_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_out_streamer_if.master  bus,
    output logic                 overrun
);
    import conv_pkg::*;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [3:0][DATA_W-1:0]       cap_q, cap_d;
    logic                         overrun_q, overrun_d;
`ifdef CONV_OUT_MAXPOOL_EN
    logic [DATA_W-1:0]            pool_q, pool_d;
    logic [DATA_W-1:0]            pool_max;

    max4_u #(.W(DATA_W)) u_max4 (
        .a (bus.o00),
        .b (bus.o01),
        .c (bus.o10),
        .d (bus.o11),
        .y (pool_max)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_O00;
            cap_q     <= '0;
            overrun_q <= 1'b0;
`ifdef CONV_OUT_MAXPOOL_EN
            pool_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            overrun_q <= overrun_d;
`ifdef CONV_OUT_MAXPOOL_EN
            pool_q    <= pool_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_d     = cap_q;
        overrun_d = overrun_q;
`ifdef CONV_OUT_MAXPOOL_EN
        pool_d    = pool_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_STREAM;
                    idx_d   = IDX_O00;
                    cap_d   = {bus.o11, bus.o10, bus.o01, bus.o00};
`ifdef CONV_OUT_MAXPOOL_EN
                    pool_d  = pool_max;
`endif
                end
            end
            ST_STREAM: begin
                // a tile offered while busy is dropped, including on the last-beat edge
                if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                if (bus.m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = IDX_O00;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_O00;
            end
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == ST_IDLE);
        bus.m_valid  = (state_q == ST_STREAM);
        bus.m_idx    = idx_q;
        bus.m_last   = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
        bus.m_data   = '0;
        overrun      = overrun_q;
        if (state_q == ST_STREAM) begin
            case (idx_q)
                IDX_O00:  bus.m_data = cap_q[0];
                IDX_O01:  bus.m_data = cap_q[1];
                IDX_O10:  bus.m_data = cap_q[2];
                IDX_O11:  bus.m_data = cap_q[3];
`ifdef CONV_OUT_MAXPOOL_EN
                IDX_POOL: bus.m_data = pool_q;
`endif
                default:  bus.m_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_out_streamer.sv
// tb/tb_conv_out_streamer.sv - scoreboard bench for conv_out_streamer (honours CONV_OUT_MAXPOOL_EN)
module tb_conv_out_streamer;
    import conv_pkg::*;

`ifdef CONV_OUT_MAXPOOL_EN
    localparam int BEATS = 5;
`else
    localparam int BEATS = 4;
`endif

    typedef struct {
        int data;
        int idx;
        int last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic overrun;

    conv_out_streamer_if bus ();

    conv_out_streamer dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    beat_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;

    bit    bp_en = 1'b0;
    int    bp_k  = 0;
    logic  bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // downstream ready driver
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = bp_en ? bp_pat[bp_k] : 1'b1;
            bp_k = (bp_k + 1) % 6;
        end
    end

    // monitor: pops on every transfer, checks stability across stalls
    bit    hold_v = 1'b0;
    int    hold_d, hold_i, hold_l;
    beat_t exp_b;

    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && bus.m_valid) begin
                chk("stall_data", int'(bus.m_data), hold_d);
                chk("stall_idx", int'(bus.m_idx), hold_i);
                chk("stall_last", int'(bus.m_last), hold_l);
            end
            hold_v = 1'b0;
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", int'(bus.m_data), -1);
                end else begin
                    exp_b = sb.pop_front();
                    chk("beat_data", int'(bus.m_data), exp_b.data);
                    chk("beat_idx", int'(bus.m_idx), exp_b.idx);
                    chk("beat_last", int'(bus.m_last), exp_b.last);
                end
            end else if (bus.m_valid) begin
                hold_v = 1'b1;
                hold_d = int'(bus.m_data);
                hold_i = int'(bus.m_idx);
                hold_l = int'(bus.m_last);
            end
        end
    end

    // called at posedge+1; in_valid is seen by the following edge
    task automatic tile(input int a, input int b, input int c, input int d,
                        input int pool, input bit accept);
        bus.in_valid = 1'b1;
        bus.o00 = 8'(a);
        bus.o01 = 8'(b);
        bus.o10 = 8'(c);
        bus.o11 = 8'(d);
        if (accept) begin
            sb.push_back('{a, 0, 0});
            sb.push_back('{b, 1, 0});
            sb.push_back('{c, 2, 0});
            sb.push_back('{d, 3, (BEATS == 4) ? 1 : 0});
            if (BEATS == 5) sb.push_back('{pool, 4, 1});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() == 0 && bus.in_ready) done = 1'b1;
        end
        chk(name, int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int cyc;

    initial begin
        bus.in_valid = 1'b0;
        bus.o00 = '0;
        bus.o01 = '0;
        bus.o10 = '0;
        bus.o11 = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_data", int'(bus.m_data), 0);
        chk("rst_m_last", int'(bus.m_last), 0);
        chk("rst_m_idx", int'(bus.m_idx), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        tile(67, 74, 34, 59, 74, 1'b1);
        wait_drain("basic_drain", cyc);
        chk("basic_period", cyc, BEATS);

        bp_en = 1'b1;
        tile(67, 74, 34, 59, 74, 1'b1);
        wait_drain("bp_drain", cyc);
        bp_en = 1'b0;

        tile(10, 20, 30, 40, 40, 1'b1);
        wait_drain("b2b_first_drain", cyc);
        tile(200, 100, 250, 5, 250, 1'b1);
        wait_drain("b2b_second_drain", cyc);
        chk("b2b_overrun", int'(overrun), 0);

        tile(67, 74, 34, 59, 74, 1'b1);
        chk("busy_in_ready", int'(bus.in_ready), 0);
        tile(1, 2, 3, 4, 4, 1'b0);
        chk("overrun_set", int'(overrun), 1);
        wait_drain("overrun_drain", cyc);
        chk("overrun_hold", int'(overrun), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_hold_late", int'(overrun), 1);

        tile(11, 22, 33, 44, 44, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", int'(bus.m_valid), 0);
        chk("midrst_m_data", int'(bus.m_data), 0);
        chk("midrst_m_idx", int'(bus.m_idx), 0);
        chk("midrst_m_last", int'(bus.m_last), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_overrun", int'(overrun), 0);
        sb.delete();
        #10;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_m_valid", int'(bus.m_valid), 0);
            chk("postrst_in_ready", int'(bus.in_ready), 1);
        end

        tile(255, 255, 0, 255, 255, 1'b1);
        wait_drain("tie_drain", cyc);
        tile(0, 0, 0, 0, 0, 1'b1);
        wait_drain("zero_drain", cyc);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
- Downstream stage of the 1x1 systolic convolution core.
- Captures one 2x2 output tile (o00,o01,o10,o11) when the core flags it valid, then serializes it in raster order onto a valid/ready byte stream for the writeback/buffer stage.
- Optionally appends a 2x2 max-pool result as a fifth beat.
- in_ready backpressures the core.

Parameters:
- DATA_W, 8, width of each output element and of the stream data.
- IDX_W, 3, width of beat index output (holds 0..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  core asserts: tile on o00..o11 is valid this cycle.
- in_ready  out  1  block can accept a tile.
- o00, o01, o10, o11  in  DATA_W each  conv outputs, unsigned.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  final beat of tile.
- m_idx  out  IDX_W  beat index (0=o00, 1=o01, 2=o10, 3=o11, 4=pool).
- overrun  out  1  sticky: tile offered while in_ready low.

Behaviour:
- Reset (rst=0, async) values: state IDLE, in_ready=1, m_valid=0, m_data=0, m_last=0, m_idx=0, overrun=0; capture registers cleared.
- Reset asserted mid-stream aborts the tile; no partial beats follow after release.
- States:
  - IDLE: in_ready=1, m_valid=0.
  - STREAM: in_ready=0, m_valid=1.
- IDLE->STREAM on rising edge with in_valid=1:
  - latch all four inputs;
  - compute max of the four and register it (pool register);
  - m_idx=0, m_data=o00 visible the next cycle (capture-to-first-beat latency 1 cycle).
- STREAM, beat transfer: a beat transfers on any edge with m_valid && m_ready.
  - Non-last beat: m_idx increments and m_data shows the next element.
  - Without a transfer: m_data, m_idx and m_last hold stable. This holds for any length of backpressure.
- m_last=1 exactly when m_idx equals the final index (3, or 4 with pool).
- STREAM->IDLE on transfer of the last beat; in_ready=1 the following cycle. Minimum tile period = 1 + beats cycles.
- in_valid while in_ready=0: tile ignored, overrun set to 1 and held until reset. This also applies to in_valid on the same edge as the last-beat transfer.
- Arithmetic: max is an unsigned DATA_W comparison. On ties, any equal value gives the same result. No widening.

Optional Feature:
- Macro CONV_OUT_MAXPOOL_EN.
  - Defined: 5 beats per tile. Beat 4 is the registered max of the four elements, with m_last on beat 4.
  - Undefined: 4 beats, m_last on beat 3, no pool register or comparator synthesized, m_idx never exceeds 3.

Decomposition:
- Shared package (conv_pkg):
  - DATA_W;
  - state enum (ST_IDLE, ST_STREAM);
  - beat index constants (IDX_O00..IDX_O11, IDX_POOL);
  - LAST_IDX derived from CONV_OUT_MAXPOOL_EN.
- One natural sub-module: max4_u, a combinational unsigned 4-input maximum (two-level compare tree), instantiated only under the macro.

Test Plan:
- Basic tile:
  - Stimulus: reset, release, in_valid pulse with o00=67, o01=74, o10=34, o11=59, m_ready=1.
  - Required response: beats 67,74,34,59 on consecutive cycles, idx 0..3. With macro, fifth beat 74 with m_last; otherwise m_last on 59.
- Backpressure:
  - Stimulus: same tile, m_ready toggled 1,0,0,1,0,1...
  - Required response: no beat lost or duplicated; m_data/m_idx stable whenever m_ready=0; order unchanged.
- Overrun:
  - Stimulus: second in_valid (o00=1,o01=2,o10=3,o11=4) during streaming of the first tile.
  - Required response: ignored, first tile completes intact, overrun=1 and stays 1.
- Back-to-back:
  - Stimulus: new in_valid on the first cycle in_ready returns high.
  - Required response: accepted, overrun stays 0, second tile streams correctly.
- Reset mid-stream:
  - Stimulus: rst=0 after beat 1 transfers, asynchronously between edges.
  - Required response: m_valid falls immediately, all outputs at reset values; after release in_ready=1, no stale beats.
- Max tie/edge:
  - Stimulus: tile 255,255,0,255 (macro defined).
  - Required response: pool beat 255; tile 0,0,0,0 gives pool beat 0.
